// File: rtl/clk_div_sched.sv
// Run-time controller for a power-of-two clock divider: free-running counter,
// registered 50% div_clk, period-end tick, and boundary-aligned ratio/stop changes.
module clk_div_sched #(
  parameter int MAX_LOG2 = 5,
  parameter int LOG2_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [LOG2_W-1:0] cfg_log2,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [LOG2_W-1:0] active_log2,
  output logic              div_clk,
  output logic              tick,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [LOG2_W-1:0]   active_q, active_d;
  logic [LOG2_W-1:0]   pend_q, pend_d;
  logic                div_clk_q, div_clk_d;
  logic                tick_q, tick_d;
  logic                cfg_err_q, cfg_err_d;

  logic [MAX_LOG2-1:0] mask;
  logic [MAX_LOG2-1:0] cnt_inc;
  logic                msb;
  logic                wrap;
  logic                xfer;
  logic                legal;

  assign cfg_ready   = (state_q != ST_PEND);
  assign busy        = (state_q != ST_IDLE);
  assign active_log2 = active_q;
  assign div_clk     = div_clk_q;
  assign tick        = tick_q;
  assign cfg_err     = cfg_err_q;

  assign xfer  = cfg_valid & cfg_ready;
  assign legal = (cfg_log2 != '0) && (cfg_log2 <= LOG2_W'(MAX_LOG2));

  // Mask keeps the low active_log2 bits, so the counter wraps at 2^active_log2.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LOG2; i++) begin
      if (LOG2_W'(i) < active_q) mask[i] = 1'b1;
    end
  end

  assign cnt_inc = (cnt_q + MAX_LOG2'(1)) & mask;
  assign wrap    = (cnt_inc == '0);

  // div_clk is the top counter bit of the current ratio: high for the upper half.
  always_comb begin
    msb = 1'b0;
    for (int i = 0; i < MAX_LOG2; i++) begin
      if (LOG2_W'(i) == active_q - LOG2_W'(1)) msb = cnt_inc[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pend_d    = pend_q;
    div_clk_d = 1'b0;
    tick_d    = 1'b0;
    cfg_err_d = xfer & ~legal;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (xfer && legal) active_d = cfg_log2;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d     = cnt_inc;
        div_clk_d = msb;
        tick_d    = wrap;
        if (wrap && !en) begin
          // Stopping on a boundary: a request landing here is applied directly.
          state_d = ST_IDLE;
          if (xfer && legal) active_d = cfg_log2;
        end else if (xfer && legal) begin
          pend_d  = cfg_log2;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        cnt_d     = cnt_inc;
        div_clk_d = msb;
        tick_d    = wrap;
        if (wrap) begin
          active_d = pend_q;
          state_d  = en ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      active_q  <= LOG2_W'(1);
      pend_q    <= '0;
      div_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed and randomized checks for clk_div_sched against hand-derived values
// and an arithmetic reference model.
module tb_clk_div_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_log2 = 3'd0;
  logic       cfg_ready, cfg_err, div_clk, tick, busy;
  logic [2:0] active_log2;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state (0=idle 1=run 2=pend)
  int m_state, m_cnt, m_act, m_pend, m_div, m_tick, m_err;

  clk_div_sched #(.MAX_LOG2(5), .LOG2_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_log2(cfg_log2),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .active_log2(active_log2),
    .div_clk(div_clk), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, cfg_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_act"}, active_log2, 1);
    check({tag, "_div"}, div_clk, 0);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_err"}, cfg_err, 0);
  endtask

  task automatic model_init();
    m_state = 0; m_cnt = 0; m_act = 1; m_pend = 0; m_div = 0; m_tick = 0; m_err = 0;
  endtask

  // Next model state from the current model state and the inputs about to be sampled.
  task automatic model_step();
    int  period, nc, ns, na, np;
    bit  acc, ok;
    acc = cfg_valid && (m_state != 2);
    ok  = (cfg_log2 >= 1) && (cfg_log2 <= 5);
    ns = m_state; na = m_act; np = m_pend;
    m_err = acc && !ok;
    if (m_state == 0) begin
      nc = 0; m_div = 0; m_tick = 0;
      if (acc && ok) na = cfg_log2;
      if (en) ns = 1;
    end else begin
      period = 1 << m_act;
      nc = (m_cnt + 1) % period;
      m_div = (nc >= period / 2);
      m_tick = (nc == 0);
      if (m_state == 1) begin
        if (nc == 0 && !en) begin
          ns = 0;
          if (acc && ok) na = cfg_log2;
        end else if (acc && ok) begin
          np = cfg_log2; ns = 2;
        end
      end else if (nc == 0) begin
        na = m_pend;
        ns = en ? 1 : 0;
      end
    end
    m_state = ns; m_cnt = nc; m_act = na; m_pend = np;
  endtask

  initial begin
    int prev_tick, prev_act, prev_busy, prev_div, hi_len;

    // reset state, applied asynchronously
    #1 rst = 1'b1;
    #1 check_reset("rst");
    step(); step();
    rst = 1'b0;

    // /2 run: toggling every clk, tick every 2nd cycle
    en = 1'b1;
    step();
    check("run_busy", busy, 1);
    check("run_div0", div_clk, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("d2_div", div_clk, k % 2);
      check("d2_tick", tick, (k % 2 == 0));
    end

    // ratio change to /8 requested mid-period
    cfg_valid = 1'b1; cfg_log2 = 3'd3;
    check("pre_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("pend_ready", cfg_ready, 0);
    check("pend_div", div_clk, 1);
    check("pend_act", active_log2, 1);
    step();
    check("sw_tick", tick, 1);
    check("sw_act", active_log2, 3);
    check("sw_ready", cfg_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("d8_div", div_clk, (k >= 4 && k <= 7));
      check("d8_tick", tick, (k == 8));
    end

    // illegal ratios 0 and 6
    cfg_valid = 1'b1; cfg_log2 = 3'd0;
    step();
    cfg_valid = 1'b0;
    check("err0", cfg_err, 1);
    check("err0_ready", cfg_ready, 1);
    check("err0_act", active_log2, 3);
    check("err0_div", div_clk, 0);
    step();
    check("err0_clr", cfg_err, 0);
    cfg_valid = 1'b1; cfg_log2 = 3'd6;
    step();
    cfg_valid = 1'b0;
    check("err6", cfg_err, 1);
    check("err6_ready", cfg_ready, 1);
    check("err6_act", active_log2, 3);
    step();
    check("err6_clr", cfg_err, 0);
    check("err6_div", div_clk, 1);
    repeat (3) step();
    step();
    check("err_tick", tick, 1);

    // move to /32, then deferred stop
    cfg_valid = 1'b1; cfg_log2 = 3'd5;
    step();
    cfg_valid = 1'b0;
    check("p32_ready", cfg_ready, 0);
    repeat (6) step();
    step();
    check("p32_tick", tick, 1);
    check("p32_act", active_log2, 5);
    repeat (5) step();
    en = 1'b0;
    repeat (26) step();
    check("stop31_busy", busy, 1);
    check("stop31_div", div_clk, 1);
    check("stop31_tick", tick, 0);
    step();
    check("stop_tick", tick, 1);
    check("stop_div", div_clk, 0);
    check("stop_busy", busy, 0);
    step();
    check("idle_tick", tick, 0);
    check("idle_div", div_clk, 0);
    check("idle_busy", busy, 0);

    // stop cancelled by en re-raised at cnt=20
    en = 1'b1;
    step();
    repeat (5) step();
    en = 1'b0;
    repeat (15) step();
    en = 1'b1;
    repeat (11) step();
    step();
    check("cancel_tick", tick, 1);
    check("cancel_busy", busy, 1);
    step();
    check("cancel_run", busy, 1);
    check("cancel_tick0", tick, 0);

    // async reset with a pending change
    cfg_valid = 1'b1; cfg_log2 = 3'd2;
    step();
    cfg_valid = 1'b0;
    repeat (11) step();
    check("pr_busy", busy, 1);
    check("pr_ready", cfg_ready, 0);
    #2 rst = 1'b1;
    #1 check_reset("arst");
    step();
    check_reset("arst_hold");
    rst = 1'b0;
    step();
    check("post_div0", div_clk, 0);
    step();
    check("post_div1", div_clk, 1);
    check("post_act", active_log2, 1);
    step();
    check("post_tick", tick, 1);
    check("post_act2", active_log2, 1);
    step();
    check("post_div3", div_clk, 1);

    // randomized stress against the model
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    step();
    rst = 1'b0;
    model_init();
    prev_tick = 0; prev_act = 1; prev_busy = 0; prev_div = 0; hi_len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!cfg_valid || cfg_ready) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_log2  = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      model_step();
      step();
      check("rnd_div", div_clk, m_div);
      check("rnd_tick", tick, m_tick);
      check("rnd_act", active_log2, m_act);
      check("rnd_ready", cfg_ready, (m_state != 2));
      check("rnd_busy", busy, (m_state != 0));
      check("rnd_err", cfg_err, m_err);
      if (prev_tick) check("rnd_tick_b2b", tick, 0);
      if (prev_busy && active_log2 != prev_act) check("rnd_act_wrap", tick, 1);
      if (div_clk) hi_len++;
      else if (prev_div) begin
        check("rnd_high_len", hi_len, 1 << (prev_act - 1));
        hi_len = 0;
      end
      prev_tick = tick; prev_act = active_log2; prev_busy = busy; prev_div = div_clk;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
